pq_exerciser: RTL and testbench

- Self-checking stimulus/response engine for the 3-in/2-out truth-table block (inputs A,B,C; outputs P,Q).
- On START it drives A,B,C through all eight codes 000..111 and samples P,Q after a settle delay.
- Compares each sample against a parameterised expected table, with a don't-care mask.
- Reports pass/fail, error count and first failing vector. Used on-board and in simulation as the driving end of the truth-table interface.

---
 rtl/pq_pkg.sv | 39 +++
 rtl/pq_exerciser_if.sv | 17 +
 rtl/pq_exerciser.sv | 194 +++++++++++++++++++
 tb/tb_pq_exerciser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// ----------------------------------------------------------------------------
// pq_pkg
// Shared definitions for the 3-in/2-out truth-table block and its exerciser.
// The default expected table and care mask live here so that the DUT
// testbench and the exerciser share a single truth-table definition.
// No ports (package).
// ----------------------------------------------------------------------------
package pq_pkg;

   // Exerciser sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } pq_state_t;

   localparam int NUM_VECTORS = 8;

   // Expected {P,Q} for vector i sits at bits [2i+1:2i]
   localparam logic [15:0] PQ_EXP_TABLE = 16'h0A1D;
   // Per-bit compare enable; bit0 (Q at vector 000) is don't-care
   localparam logic [15:0] PQ_CARE_MASK = 16'hFFFE;

   // Masked difference between an observed {P,Q} pair and the table entry
   function automatic logic [1:0] pq_mismatch(
      input logic [1:0]  pq,
      input logic [2:0]  idx,
      input logic [15:0] exp_tbl,
      input logic [15:0] care_tbl
   );
      logic [1:0] exp_bits;
      logic [1:0] care_bits;
      exp_bits  = exp_tbl[{idx, 1'b0} +: 2];
      care_bits = care_tbl[{idx, 1'b0} +: 2];
      return (pq ^ exp_bits) & care_bits;
   endfunction

endpackage : pq_pkg

// File: rtl/pq_exerciser_if.sv
// ----------------------------------------------------------------------------
// pq_tt_if
// Truth-table bus between the exerciser (master) and the block under test
// (slave).
//   A,B,C : stimulus, master -> slave ({A,B,C} is the vector index, A = MSB)
//   P,Q   : response, slave -> master
// ----------------------------------------------------------------------------
interface pq_tt_if;
   logic A;
   logic B;
   logic C;
   logic P;
   logic Q;

   modport master (output A, output B, output C, input P, input Q);
   modport slave  (input A, input B, input C, output P, output Q);
endinterface : pq_tt_if

// File: rtl/pq_exerciser.sv
// ----------------------------------------------------------------------------
// pq_exerciser
// Stimulus/response engine for the 3-in/2-out truth-table block. On START it
// steps {A,B,C} through 000..111, holds each code for SETTLE_CYCLES cycles,
// then samples {P,Q} and compares against EXP_TABLE under CARE_MASK.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous active-high reset
//   START      in   begin a run (honoured only in IDLE)
//   tt         master modport of pq_tt_if (A,B,C out registered; P,Q in)
//   BUSY       out  run in progress
//   DONE       out  one-cycle pulse at run completion
//   PASS       out  1 when the last run had no failing vector
//   ERR_COUNT  out  failing vectors in the last run (0..8)
//   FAIL_VALID out  at least one failure recorded
//   FIRST_FAIL out  index of the first failing vector
//   RESP_LOG   out  raw {P,Q} per vector (only with PQEX_RESP_LOG_EN)
//
// Build option: define PQEX_RESP_LOG_EN to add the RESP_LOG output.
// ----------------------------------------------------------------------------
module pq_exerciser
   import pq_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] EXP_TABLE     = PQ_EXP_TABLE,
   parameter logic [15:0] CARE_MASK     = PQ_CARE_MASK
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   pq_tt_if.master     tt,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS,
   output logic [3:0]  ERR_COUNT,
   output logic        FAIL_VALID,
   output logic [2:0]  FIRST_FAIL
`ifdef PQEX_RESP_LOG_EN
   ,
   output logic [15:0] RESP_LOG
`endif
);

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_IDX   = 3'(NUM_VECTORS - 1);

   pq_state_t   state_r,      state_nxt_s;
   logic [2:0]  idx_r,        idx_nxt_s;
   logic [3:0]  cnt_r,        cnt_nxt_s;
   logic [2:0]  abc_r,        abc_nxt_s;
   logic        busy_r,       busy_nxt_s;
   logic        done_r,       done_nxt_s;
   logic        pass_r,       pass_nxt_s;
   logic [3:0]  err_r,        err_nxt_s;
   logic        fail_valid_r, fail_valid_nxt_s;
   logic [2:0]  first_fail_r, first_fail_nxt_s;
   logic [1:0]  mismatch_s;
   logic [3:0]  err_upd_s;
   logic [15:0] log_r,        log_nxt_s;

   // Masked compare of the live response against the current vector's entry
   always_comb begin
      mismatch_s = pq_mismatch({tt.P, tt.Q}, idx_r, EXP_TABLE, CARE_MASK);
      if (mismatch_s != 2'b00) begin
         err_upd_s = err_r + 4'd1;
      end else begin
         err_upd_s = err_r;
      end
   end

   // Next-state and next-output logic for the run sequencer
   always_comb begin
      state_nxt_s      = state_r;
      idx_nxt_s        = idx_r;
      cnt_nxt_s        = cnt_r;
      abc_nxt_s        = abc_r;
      busy_nxt_s       = busy_r;
      done_nxt_s       = 1'b0;
      pass_nxt_s       = pass_r;
      err_nxt_s        = err_r;
      fail_valid_nxt_s = fail_valid_r;
      first_fail_nxt_s = first_fail_r;
      log_nxt_s        = log_r;

      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt_s      = ST_WAIT;
               idx_nxt_s        = 3'd0;
               cnt_nxt_s        = CNT_RELOAD;
               abc_nxt_s        = 3'd0;
               busy_nxt_s       = 1'b1;
               pass_nxt_s       = 1'b0;
               err_nxt_s        = 4'd0;
               fail_valid_nxt_s = 1'b0;
               first_fail_nxt_s = 3'd0;
               log_nxt_s        = 16'h0000;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_SAMPLE;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end

         ST_SAMPLE: begin
            err_nxt_s = err_upd_s;
            log_nxt_s[{idx_r, 1'b0} +: 2] = {tt.P, tt.Q};
            // Only the first failing vector is latched
            if ((mismatch_s != 2'b00) && !fail_valid_r) begin
               fail_valid_nxt_s = 1'b1;
               first_fail_nxt_s = idx_r;
            end else begin
               fail_valid_nxt_s = fail_valid_r;
            end
            if (idx_r != LAST_IDX) begin
               idx_nxt_s   = idx_r + 3'd1;
               abc_nxt_s   = idx_r + 3'd1;
               cnt_nxt_s   = CNT_RELOAD;
               state_nxt_s = ST_WAIT;
            end else begin
               // Results are registered on entry to FINISH so DONE/PASS align
               state_nxt_s = ST_FINISH;
               abc_nxt_s   = 3'd0;
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               pass_nxt_s  = (err_upd_s == 4'd0);
            end
         end

         ST_FINISH: begin
            state_nxt_s = ST_IDLE;
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r      <= ST_IDLE;
         idx_r        <= 3'd0;
         cnt_r        <= 4'd0;
         abc_r        <= 3'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_r        <= 4'd0;
         fail_valid_r <= 1'b0;
         first_fail_r <= 3'd0;
         log_r        <= 16'h0000;
      end else begin
         state_r      <= state_nxt_s;
         idx_r        <= idx_nxt_s;
         cnt_r        <= cnt_nxt_s;
         abc_r        <= abc_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         pass_r       <= pass_nxt_s;
         err_r        <= err_nxt_s;
         fail_valid_r <= fail_valid_nxt_s;
         first_fail_r <= first_fail_nxt_s;
         log_r        <= log_nxt_s;
      end
   end

   assign tt.A       = abc_r[2];
   assign tt.B       = abc_r[1];
   assign tt.C       = abc_r[0];
   assign BUSY       = busy_r;
   assign DONE       = done_r;
   assign PASS       = pass_r;
   assign ERR_COUNT  = err_r;
   assign FAIL_VALID = fail_valid_r;
   assign FIRST_FAIL = first_fail_r;

`ifdef PQEX_RESP_LOG_EN
   assign RESP_LOG = log_r;
`else
   // Log register is unused without the output; keep it trivially consumed
   logic log_unused_s;
   assign log_unused_s = ^log_r;
`endif

endmodule : pq_exerciser

// File: tb/tb_pq_exerciser.sv
// ----------------------------------------------------------------------------
// tb_pq_exerciser
// Self-checking bench for pq_exerciser. A behavioural truth-table block is
// driven from resp_tbl; expected run results are pushed to a scoreboard when
// START is issued and popped when DONE is due. Cycle-level timing of ABC,
// BUSY and DONE is checked against the S=2 schedule.
// ----------------------------------------------------------------------------
module tb_pq_exerciser;
   import pq_pkg::*;

   localparam int S        = 2;
   localparam int DONE_CYC = 8 * (S + 1) + 1;

   typedef struct packed {
      logic [3:0]  err;
      logic        fv;
      logic [2:0]  ff;
      logic        pass;
      logic [15:0] log;
   } res_t;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic        BUSY;
   logic        DONE;
   logic        PASS;
   logic [3:0]  ERR_COUNT;
   logic        FAIL_VALID;
   logic [2:0]  FIRST_FAIL;
`ifdef PQEX_RESP_LOG_EN
   logic [15:0] RESP_LOG;
`endif

   logic [15:0] resp_tbl;
   logic [2:0]  abc_s;
   int          vec_cnt;
   int          miscmp_cnt;
   res_t        sb_q[$];

   pq_tt_if tt_bus ();

   pq_exerciser #(.SETTLE_CYCLES(S)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .tt         (tt_bus.master),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .PASS       (PASS),
      .ERR_COUNT  (ERR_COUNT),
      .FAIL_VALID (FAIL_VALID),
      .FIRST_FAIL (FIRST_FAIL)
`ifdef PQEX_RESP_LOG_EN
      ,
      .RESP_LOG   (RESP_LOG)
`endif
   );

   // Behavioural block under test: combinational lookup into resp_tbl
   assign abc_s    = {tt_bus.A, tt_bus.B, tt_bus.C};
   assign tt_bus.P = resp_tbl[{abc_s, 1'b1}];
   assign tt_bus.Q = resp_tbl[{abc_s, 1'b0}];

   // Free-running clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result for a given response table, computed vector by vector
   function automatic res_t model(input logic [15:0] rt);
      res_t r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         logic [1:0] got_pq;
         logic [1:0] exp_pq;
         logic [1:0] care;
         got_pq = {rt[2*i+1], rt[2*i]};
         exp_pq = {PQ_EXP_TABLE[2*i+1], PQ_EXP_TABLE[2*i]};
         care   = {PQ_CARE_MASK[2*i+1], PQ_CARE_MASK[2*i]};
         if (((got_pq ^ exp_pq) & care) != 2'b00) begin
            if (!r.fv) begin
               r.fv = 1'b1;
               r.ff = 3'(i);
            end
            r.err = r.err + 4'd1;
         end
      end
      r.pass = (r.err == 4'd0);
      r.log  = rt;
      return r;
   endfunction

   // One full run; optionally pulses START while busy and in the FINISH cycle
   task automatic do_run(input string name, input logic [15:0] rt, input bit extra_start);
      res_t exp_r;
      res_t got_r;
      resp_tbl = rt;
      @(negedge CLK);
      START = 1'b1;
      sb_q.push_back(model(rt));
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      for (int k = 1; k <= DONE_CYC + 1; k++) begin
         if (k == 1) begin
            check_val({name, ":clr_err"},  32'(ERR_COUNT),  32'd0);
            check_val({name, ":clr_fv"},   32'(FAIL_VALID), 32'd0);
            check_val({name, ":clr_pass"}, 32'(PASS),       32'd0);
         end
         if (k < DONE_CYC) begin
            check_val({name, ":abc"},  32'(abc_s), 32'((k - 1) / (S + 1)));
            check_val({name, ":busy"}, 32'(BUSY),  32'd1);
            check_val({name, ":done"}, 32'(DONE),  32'd0);
         end else if (k == DONE_CYC) begin
            check_val({name, ":done"}, 32'(DONE),  32'd1);
            check_val({name, ":busy"}, 32'(BUSY),  32'd0);
            check_val({name, ":abc"},  32'(abc_s), 32'd0);
            check_val({name, ":sb_nonempty"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() != 0) begin
               exp_r = sb_q.pop_front();
               got_r = '0;
               got_r.err  = ERR_COUNT;
               got_r.fv   = FAIL_VALID;
               got_r.ff   = exp_r.fv ? FIRST_FAIL : 3'd0;
               got_r.pass = PASS;
`ifdef PQEX_RESP_LOG_EN
               got_r.log  = RESP_LOG;
`else
               got_r.log  = exp_r.log;
`endif
               check_val({name, ":err"},  32'(got_r.err),  32'(exp_r.err));
               check_val({name, ":fv"},   32'(got_r.fv),   32'(exp_r.fv));
               check_val({name, ":ff"},   32'(got_r.ff),   32'(exp_r.ff));
               check_val({name, ":pass"}, 32'(got_r.pass), 32'(exp_r.pass));
               check_val({name, ":log"},  32'(got_r.log),  32'(exp_r.log));
            end
         end else begin
            // Cycle after FINISH: back in IDLE, pulse gone, results held
            check_val({name, ":done_end"}, 32'(DONE), 32'd0);
            check_val({name, ":busy_end"}, 32'(BUSY), 32'd0);
            check_val({name, ":pass_hold"}, 32'(PASS), 32'(model(rt).pass));
         end
         if (extra_start && (k == S + 2 || k == DONE_CYC)) begin
            START = 1'b1;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
      end
      START = 1'b0;
      if (extra_start) begin
         // START sampled in FINISH must not have launched a second run
         check_val({name, ":no_rerun"}, 32'(BUSY), 32'd0);
      end
   endtask

   logic [15:0] fault_tbl;

   initial begin
      vec_cnt    = 0;
      miscmp_cnt = 0;
      RESET      = 1'b1;
      START      = 1'b0;
      resp_tbl   = PQ_EXP_TABLE;
      // P forced high at vectors 011 and 110
      fault_tbl  = PQ_EXP_TABLE | 16'h2080;

      // Reset then idle
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_val("idle:abc",  32'(abc_s),      32'd0);
         check_val("idle:busy", 32'(BUSY),       32'd0);
         check_val("idle:done", 32'(DONE),       32'd0);
         check_val("idle:pass", 32'(PASS),       32'd0);
         check_val("idle:err",  32'(ERR_COUNT),  32'd0);
         check_val("idle:fv",   32'(FAIL_VALID), 32'd0);
         check_val("idle:ff",   32'(FIRST_FAIL), 32'd0);
         @(negedge CLK);
      end

      do_run("golden",   PQ_EXP_TABLE, 1'b0);
      do_run("dontcare", PQ_EXP_TABLE & 16'hFFFC, 1'b0);
      do_run("faulty",   fault_tbl, 1'b0);
      check_val("faulty:ff_abs", 32'(FIRST_FAIL), 32'd3);
      do_run("busy_start", PQ_EXP_TABLE ^ 16'h4000, 1'b1);
      do_run("rerun",    PQ_EXP_TABLE, 1'b0);
      for (int r = 0; r < 4; r++) begin
         do_run("random", 16'($urandom), 1'b0);
      end

      // Mid-run reset at vector 4's SAMPLE cycle
      resp_tbl = fault_tbl;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      for (int k = 1; k < 5 * (S + 1); k++) begin
         @(negedge CLK);
      end
      check_val("midrst:err_before", 32'(ERR_COUNT), 32'd1);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check_val("midrst:abc",  32'(abc_s),      32'd0);
      check_val("midrst:busy", 32'(BUSY),       32'd0);
      check_val("midrst:err",  32'(ERR_COUNT),  32'd0);
      check_val("midrst:fv",   32'(FAIL_VALID), 32'd0);
      check_val("midrst:done", 32'(DONE),       32'd0);
      for (int k = 0; k < DONE_CYC + 5; k++) begin
         @(negedge CLK);
         if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            check_val("midrst:quiet", {30'd0, DONE, BUSY}, 32'd0);
         end else begin
            vec_cnt++;
         end
      end

      // A fresh run after the abandoned one behaves normally
      do_run("post_rst", fault_tbl, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule : tb_pq_exerciser
